// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and FSM state type for the serial subtractor
// Purpose: digit width and controller state encoding shared by the
//          interface, the top level and the nibble datapath.
// Ports:   none (package).
package arith_pkg;

  // Width of one serial digit.
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_nibble_subtractor_if.sv
// rtl/serial_nibble_subtractor_if.sv - operand/result handshake bundle
// Purpose: groups the input handshake (operands + borrow-in) and the
//          output handshake (difference + borrow-out) of the subtractor.
// Signals: in_valid/in_ready, minuend, subtrahend, bin   (request side)
//          out_valid/out_ready, diff, bout              (result side)
// Modports: master = producer/consumer around the block, slave = the block.
interface serial_nibble_subtractor_if
  import arith_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;

  modport master (
    output in_valid, minuend, subtrahend, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, minuend, subtrahend, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/nibble_subtractor.sv
// rtl/nibble_subtractor.sv - combinational 4-bit ripple-borrow subtractor
// Purpose: d = a - b - bin over one nibble, built from four 1-bit
//          full subtractors chained through their borrows.
// Ports:   a[3:0], b[3:0], bin  -> d[3:0], bout
module nibble_subtractor
  import arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  // w_bor[i] is the borrow into bit i; w_bor[NIBBLE_W] leaves the nibble.
  logic [NIBBLE_W:0] w_bor;

  assign w_bor[0] = bin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fs
    assign d[i]       = a[i] ^ b[i] ^ w_bor[i];
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign w_bor[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bor[i]);
  end

  assign bout = w_bor[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_subtractor.sv
// rtl/serial_nibble_subtractor.sv - digit-serial W-bit subtractor with valid/ready handshakes
// Purpose: latches A, B and borrow-in, then computes A - B - bin one nibble
//          per cycle (LSB first) through a single nibble_subtractor, and
//          presents diff/bout until the consumer accepts them.
// Ports:   clk, rst (sync, active-high)
//          bus (slave): in_valid/in_ready, minuend, subtrahend, bin,
//                       out_valid/out_ready, diff, bout
module serial_nibble_subtractor
  import arith_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  serial_nibble_subtractor_if.slave  bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  // Keep the index at least one bit wide so NIBBLES=1 still elaborates.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_diff;
  logic          r_borrow;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_d_nib;
  logic                w_bout_nib;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_subtractor u_nib (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .bin  (r_borrow),
    .d    (w_d_nib),
    .bout (w_bout_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.minuend;
            r_b        <= bus.subtrahend;
            r_borrow   <= bus.bin;
            r_idx      <= '0;
            r_diff     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IW'(k)) begin
              r_diff[k*NIBBLE_W +: NIBBLE_W] <= w_d_nib;
            end
          end
          // After the last nibble this holds the overall borrow-out.
          r_borrow <= w_bout_nib;
          if (r_idx == LAST_IDX) begin
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  // The partial difference builds up during RUN; only expose it in DONE.
  assign bus.diff      = r_out_valid ? r_diff : '0;
  assign bus.bout      = r_out_valid & r_borrow;

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// tb/tb_serial_nibble_subtractor.sv - self-checking bench for serial_nibble_subtractor
module tb_serial_nibble_subtractor;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic rst;

  serial_nibble_subtractor_if #(.NIBBLES(N)) bus ();

  serial_nibble_subtractor #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: one outstanding operation, result from plain arithmetic.
  logic         m_pending;
  int           m_age;
  logic [W-1:0] m_diff;
  logic         m_bout;

  always @(posedge clk) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_age     <= 0;
    end else if (!m_pending) begin
      if (bus.in_valid) begin
        m_pending <= 1'b1;
        m_age     <= 0;
        {m_bout, m_diff} <= {1'b0, bus.minuend} - {1'b0, bus.subtrahend} - 17'(bus.bin);
      end
    end else begin
      if (m_age >= N && bus.out_ready) m_pending <= 1'b0;
      else if (m_age < N) m_age <= m_age + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                    input int stall, input bit poke,
                    output logic [W-1:0] d, output logic bo, output int lat);
    int t;
    t = 0;
    d = '0;
    bo = 1'b0;
    lat = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.minuend    = a;
    bus.subtrahend = b;
    bus.bin        = bi;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (poke) begin
      bus.minuend    = ~a;
      bus.subtrahend = a;
      bus.bin        = ~bi;
      bus.in_valid   = 1'b1;
    end
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
      return;
    end
    d  = bus.diff;
    bo = bus.bout;
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    logic         bo;
    int           lat;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.minuend    = '0;
    bus.subtrahend = '0;
    bus.bin        = 1'b0;
    bus.out_ready  = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          chk("cyc_in_ready",  32'(bus.in_ready),  32'(!m_pending));
          chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_pending && m_age >= N));
          chk("cyc_diff", 32'(bus.diff),
              (m_pending && m_age >= N) ? 32'(m_diff) : 32'd0);
          chk("cyc_bout", 32'(bus.bout),
              (m_pending && m_age >= N) ? 32'(m_bout) : 32'd0);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff",      32'(bus.diff),      32'd0);
    chk("rst_bout",      32'(bus.bout),      32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, d, bo, lat);
    chk("d1_diff",  32'(d),      32'h1000);
    chk("d1_bout",  32'(bo),     32'd0);
    chk("d1_lat",   32'(lat),    32'd4);
    chk("d1_model", 32'(m_diff), 32'h1000);

    op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, d, bo, lat);
    chk("d2_diff",  32'(d),      32'hFFFF);
    chk("d2_bout",  32'(bo),     32'd1);
    chk("d2_model", 32'(m_bout), 32'd1);

    op(16'h0005, 16'h0005, 1'b1, 0, 1'b0, d, bo, lat);
    chk("d3_diff", 32'(d),  32'hFFFF);
    chk("d3_bout", 32'(bo), 32'd1);

    op(16'h8000, 16'h0001, 1'b0, 5, 1'b0, d, bo, lat);
    chk("d4_diff",     32'(d),            32'h7FFF);
    chk("d4_bout",     32'(bo),           32'd0);
    chk("d4_in_ready", 32'(bus.in_ready), 32'd1);
    chk("d4_model",    32'(m_diff),       32'h7FFF);

    op(16'hA5A5, 16'h1111, 1'b1, 1, 1'b1, d, bo, lat);
    chk("d5_diff", 32'(d),  32'h9493);
    chk("d5_bout", 32'(bo), 32'd0);
    @(negedge clk);
    chk("d5_no_second", 32'(bus.out_valid), 32'd0);

    // Reset on the second RUN cycle discards the operation.
    bus.minuend    = 16'h4321;
    bus.subtrahend = 16'h1234;
    bus.bin        = 1'b0;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("d6_in_ready",  32'(bus.in_ready),  32'd1);
    chk("d6_out_valid", 32'(bus.out_valid), 32'd0);
    op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, d, bo, lat);
    chk("d6_diff", 32'(d),  32'h0000);
    chk("d6_bout", 32'(bo), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
         1'b0, d, bo, lat);
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
